// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern engine.
// Optional feature macro used by led_pattern_gen: LED_PWM_EN.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        BLINK  = 2'd0,
        SHIFT  = 2'd1,
        BOUNCE = 2'd2,
        COUNT  = 2'd3
    } led_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Start pattern for a mode, right-aligned in 32 bits; caller truncates to its width.
    function automatic logic [31:0] led_start(input led_mode_e mode, input int width);
        logic [63:0] ones;
        ones = (64'd1 << width) - 64'd1;
        case (mode)
            BLINK:         return ones[31:0];
            SHIFT, BOUNCE: return 32'd1;
            default:       return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Prescaler: counts 0..TICK_CYCLES-1 while enabled and pulses tick on the last count.
module tick_gen #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CNT_W       = $clog2(TICK_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // clr restarts the interval even while paused, so a new mode gets a full first step.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX) && en;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: blink, running light, ping-pong and binary count stepped by a prescaler tick.
// Define LED_PWM_EN to add a registered brightness PWM stage on the LED outputs.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int LED_W       = 4,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CNT_W       = $clog2(TICK_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [3:0]       bright,
    output logic             tick,
    output logic [LED_W-1:0] led
);

    led_mode_e        mode_q;
    logic             mode_change;
    logic [LED_W-1:0] pat;
    logic [LED_W-1:0] pat_next;
    logic [LED_W-1:0] shifted;
    logic             dir;
    logic             dir_next;

    assign mode_change = (led_mode_e'(mode) != mode_q);

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES),
        .CNT_W      (CNT_W)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (mode_change),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pat    <= LED_W'(1);
            dir    <= DIR_UP;
            mode_q <= SHIFT;
        end else begin
            pat    <= pat_next;
            dir    <= dir_next;
            mode_q <= led_mode_e'(mode);
        end
    end

    // A mode change wins over a coincident tick and reloads regardless of en.
    always_comb begin
        pat_next = pat;
        dir_next = dir;
        shifted  = '0;
        if (mode_change) begin
            pat_next = LED_W'(led_start(led_mode_e'(mode), LED_W));
            dir_next = DIR_UP;
        end else if (tick) begin
            case (mode_q)
                BLINK: pat_next = ~pat;
                SHIFT: pat_next = {pat[LED_W-2:0], pat[LED_W-1]};
                BOUNCE: begin
                    if (dir == DIR_UP) begin
                        shifted = pat << 1;
                        if (shifted[LED_W-1]) dir_next = DIR_DOWN;
                    end else begin
                        shifted = pat >> 1;
                        if (shifted[0]) dir_next = DIR_UP;
                    end
                    pat_next = shifted;
                end
                default: pat_next = pat + LED_W'(1);
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [3:0]       pwm_cnt;
    logic [LED_W-1:0] led_q;

    // Lit for pwm_cnt 0..bright, i.e. (bright+1)/16 duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 4'd0;
            led_q   <= LED_W'(1);
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            led_q   <= pat & {LED_W{pwm_cnt <= bright}};
        end
    end

    assign led = led_q;
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign led = pat;
`endif

endmodule
